// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture path.
//   - capture FSM state encoding (2-bit)
//   - default frame geometry
//   - RGB565 field widths
//   - saturating increment for the 11-bit geometry counters
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    CAPTURE  = 2'd2
  } cap_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int R565_W = 5;
  localparam int G565_W = 6;
  localparam int B565_W = 5;
  localparam int PIX_W  = R565_W + G565_W + B565_W;

  localparam int GEO_W = 11;

  // Geometry counters stick at all-ones so an overlong line/frame can never
  // wrap back around to a value that looks correct.
  function automatic logic [GEO_W-1:0] sat_inc(input logic [GEO_W-1:0] v);
    return (v == {GEO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single slow level signal.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset (output forced 0)
//   d_i    : asynchronous input level
//   q_o    : synchronized level, two clk_i edges of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: DVP camera capture into RGB565 words for the SDRAM write FIFO.
//   cmos_pclk   : sole clock (rising edge)
//   rst_pclk    : synchronous active-high reset
//   cfg_done    : camera config finished (async, synchronized here)
//   cmos_vsyn   : vsync, level VS_POL during vertical blanking
//   cmos_href   : line valid
//   cmos_data   : byte bus, high byte of each pixel first
//   fifo_full   : write FIFO full (only used to flag overflow)
//   pix_data    : {first_byte, second_byte}
//   pix_wr      : one-cycle write strobe
//   frame_start : pulse at the start of each captured frame
//   frame_done  : pulse at the end of each captured frame
//   frame_err   : sticky geometry error
//   ovf_err     : sticky strobe-while-full
//   frame_cnt   : captured frames, wrapping 16-bit
module cmos_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1
) (
  input  logic             cmos_pclk,
  input  logic             rst_pclk,
  input  logic             cfg_done,
  input  logic             cmos_vsyn,
  input  logic             cmos_href,
  input  logic [7:0]       cmos_data,
  input  logic             fifo_full,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_wr,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic             ovf_err,
  output logic [15:0]      frame_cnt
);

  localparam logic             VS_LVL = (VS_POL != 0);
  localparam logic [GEO_W-1:0] H_N    = GEO_W'(H_ACTIVE);
  localparam logic [GEO_W-1:0] V_N    = GEO_W'(V_ACTIVE);
  localparam logic [15:0]      SKIP_N = 16'(SKIP_FRAMES);

  logic cfg_sync;

  sync_2ff u_cfg_sync (
    .clk_i (cmos_pclk),
    .rst_i (rst_pclk),
    .d_i   (cfg_done),
    .q_o   (cfg_sync)
  );

  // Input stage S1 plus one delayed copy for edge detection. vsync resets to
  // the blanking level so a release mid-blanking is not seen as a new frame.
  logic       vs_s1_q, vs_s2_q, hr_s1_q, hr_s2_q;
  logic [7:0] d_s1_q;

  always_ff @(posedge cmos_pclk) begin
    if (rst_pclk) begin
      vs_s1_q <= VS_LVL;
      vs_s2_q <= VS_LVL;
      hr_s1_q <= 1'b0;
      hr_s2_q <= 1'b0;
      d_s1_q  <= '0;
    end else begin
      vs_s1_q <= cmos_vsyn;
      vs_s2_q <= vs_s1_q;
      hr_s1_q <= cmos_href;
      hr_s2_q <= hr_s1_q;
      d_s1_q  <= cmos_data;
    end
  end

  logic vs_rise, hr_fall;
  assign vs_rise = (vs_s1_q == VS_LVL) && (vs_s2_q != VS_LVL);
  assign hr_fall = !hr_s1_q && hr_s2_q;

  cap_state_e       state_q, state_d;
  logic [15:0]      skip_q, skip_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [GEO_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [GEO_W-1:0] line_cnt_q, line_cnt_d;
  logic [GEO_W-1:0] lines_eff;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             pix_wr_q, pix_wr_d;
  logic             fs_q, fs_d, fd_q, fd_d;
  logic             ferr_q, ferr_d, ovf_q, ovf_d;
  logic [15:0]      fcnt_q, fcnt_d;

  always_ff @(posedge cmos_pclk) begin
    if (rst_pclk) begin
      state_q    <= WAIT_CFG;
      skip_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      pix_data_q <= '0;
      pix_wr_q   <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      pix_data_q <= pix_data_d;
      pix_wr_q   <= pix_wr_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    lines_eff  = line_cnt_q;
    pix_data_d = pix_data_q;
    pix_wr_d   = 1'b0;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    ferr_d     = ferr_q;
    // The FIFO silently drops a word written while full; just remember it.
    ovf_d      = ovf_q | (pix_wr_q & fifo_full);
    fcnt_d     = fcnt_q;

    unique case (state_q)
      WAIT_CFG: begin
        if (cfg_sync) begin
          state_d = SKIP;
          skip_d  = '0;
        end
      end

      SKIP: begin
        if (vs_rise) begin
          if (skip_q == SKIP_N) begin
            state_d    = CAPTURE;
            fs_d       = 1'b1;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            phase_d    = 1'b0;
          end else begin
            skip_d = skip_q + 16'd1;
          end
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          // Frame end wins over any line activity in the same cycle; a line
          // that ends exactly here still gets its own length check.
          fd_d   = 1'b1;
          fs_d   = 1'b1;
          fcnt_d = fcnt_q + 16'd1;
          if (hr_fall) begin
            if (pix_cnt_q != H_N || phase_q) ferr_d = 1'b1;
            lines_eff = sat_inc(line_cnt_q);
          end
          if (lines_eff != V_N || hr_s1_q) ferr_d = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          phase_d    = 1'b0;
        end else if (hr_s1_q) begin
          phase_d = !phase_q;
          if (!phase_q) begin
            hi_d = d_s1_q;
          end else begin
            pix_data_d = {hi_q, d_s1_q};
            pix_wr_d   = 1'b1;
            pix_cnt_d  = sat_inc(pix_cnt_q);
          end
        end else begin
          phase_d = 1'b0;
          if (hr_fall) begin
            // phase_q still set here means an odd trailing byte was dropped.
            if (pix_cnt_q != H_N || phase_q) ferr_d = 1'b1;
            pix_cnt_d  = '0;
            line_cnt_d = sat_inc(line_cnt_q);
          end
        end
      end

      default: state_d = WAIT_CFG;
    endcase

    // Losing config aborts everything in flight; no further writes.
    if (!cfg_sync) begin
      state_d    = WAIT_CFG;
      pix_wr_d   = 1'b0;
      pix_data_d = pix_data_q;
      fs_d       = 1'b0;
      fd_d       = 1'b0;
      ferr_d     = ferr_q;
      fcnt_d     = fcnt_q;
      phase_d    = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_wr      = pix_wr_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_err   = ferr_q;
  assign ovf_err     = ovf_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: random-data frame stimulus for cmos_capture with a 4x2
// geometry, two settling frames, and a pixel scoreboard drained by a monitor.
module tb_cmos_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg = 1'b0;
  logic        vs  = 1'b0;
  logic        hr  = 1'b0;
  logic        full = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic [15:0] pix_data;
  logic        pix_wr, frame_start, frame_done, frame_err, ovf_err;
  logic [15:0] frame_cnt;

  cmos_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .VS_POL(1)
  ) dut (
    .cmos_pclk  (clk),
    .rst_pclk   (rst),
    .cfg_done   (cfg),
    .cmos_vsyn  (vs),
    .cmos_href  (hr),
    .cmos_data  (dat),
    .fifo_full  (full),
    .pix_data   (pix_data),
    .pix_wr     (pix_wr),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int tests = 0, fails = 0;
  int full_at = -1;
  int last_vs = -100;
  int n_fd = 0, n_fs = 0, exp_fd = 0, exp_fs = 0;

  // Reference model: a frame's data is captured when more than SK vsync
  // rises have been seen since config/reset.
  int vs_count = 0;
  bit capturing = 1'b0;
  int exp_fcnt = 0;
  bit exp_ferr = 1'b0, exp_ovf = 1'b0;
  bit frame_bad = 1'b0;
  int lines_in_frame = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: drives fifo_full for the chosen strobe cycle and checks outputs.
  always @(negedge clk) begin
    full = (cyc == full_at);
    if (pix_wr) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pix_unexpected: pix_wr with data %h, scoreboard empty (cycle %0d)", pix_data, cyc);
      end else begin
        e = q.pop_front();
        chk("pix_data", {16'h0, pix_data}, {16'h0, e.d});
        chk("pix_latency", cyc, e.c);
      end
    end
    if (frame_done) n_fd++;
    if (frame_start) begin
      n_fs++;
      chk("frame_start_latency", cyc, last_vs + 2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_pix_wr"}, {31'h0, pix_wr}, 0);
    chk({tag, "_pix_data"}, {16'h0, pix_data}, 0);
    chk({tag, "_frame_start"}, {31'h0, frame_start}, 0);
    chk({tag, "_frame_done"}, {31'h0, frame_done}, 0);
    chk({tag, "_frame_err"}, {31'h0, frame_err}, 0);
    chk({tag, "_ovf_err"}, {31'h0, ovf_err}, 0);
    chk({tag, "_frame_cnt"}, {16'h0, frame_cnt}, 0);
  endtask

  task automatic vs_pulse();
    if (capturing) begin
      exp_fd++;
      exp_fcnt = (exp_fcnt + 1) & 16'hFFFF;
      if (frame_bad || lines_in_frame != V) exp_ferr = 1'b1;
    end
    vs_count++;
    capturing = (vs_count > SK);
    if (capturing) exp_fs++;
    frame_bad = 1'b0;
    lines_in_frame = 0;
    hr = 1'b0;
    vs = 1'b1;
    last_vs = cyc;
    repeat (3) tick();
    vs = 1'b0;
    repeat ($urandom_range(2, 4)) tick();
    chk("frame_cnt", {16'h0, frame_cnt}, exp_fcnt);
    chk("frame_err", {31'h0, frame_err}, {31'h0, exp_ferr});
    chk("ovf_err", {31'h0, ovf_err}, {31'h0, exp_ovf});
    chk("frame_done_count", n_fd, exp_fd);
    chk("frame_start_count", n_fs, exp_fs);
  endtask

  // One href period of nb bytes. full_pix: 1-based pixel strobed against a
  // full FIFO (0 = none). rst_at: byte index after which reset is pulsed.
  task automatic line(input int nb, input int full_pix, input int rst_at, input bit abcd);
    logic [7:0] b0;
    b0 = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at + 1) begin
        rst = 1'b1;
        if (q.size() > 0) void'(q.pop_back());
        capturing = 1'b0;
        vs_count = 0;
        exp_fcnt = 0;
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        frame_bad = 1'b0;
        lines_in_frame = 0;
      end
      if (i == rst_at + 3) rst_checks("midline_reset");
      if (i == rst_at + 4) rst = 1'b0;
      if (abcd && i == 0) dat = 8'hAB;
      else if (abcd && i == 1) dat = 8'hCD;
      else dat = 8'($urandom_range(0, 255));
      hr = 1'b1;
      if (i % 2 == 0) begin
        b0 = dat;
      end else if (capturing) begin
        q.push_back('{d: {b0, dat}, c: cyc + 2});
        if (i / 2 + 1 == full_pix) begin
          full_at = cyc + 2;
          exp_ovf = 1'b1;
        end
      end
      tick();
    end
    hr = 1'b0;
    if (capturing) begin
      lines_in_frame++;
      if (nb != 2 * H) begin
        frame_bad = 1'b1;
        exp_ferr = 1'b1;
      end
    end
    repeat ($urandom_range(3, 5)) tick();
    if (capturing) chk("frame_err_line", {31'h0, frame_err}, {31'h0, exp_ferr});
  endtask

  task automatic frame(input int bad_line, input int bad_nb, input int full_pix,
                       input int rst_line, input int rst_at, input bit abcd);
    vs_pulse();
    for (int l = 0; l < V; l++)
      line((l == bad_line) ? bad_nb : 2 * H, (l == 0) ? full_pix : 0,
           (l == rst_line) ? rst_at : -10, abcd && (l == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (4) tick();
    rst_checks("reset");
    rst = 1'b0;
    cfg = 1'b1;
    repeat (5) tick();
    frame(-1, 0, 0, -1, -10, 1'b0);   // settling frame 1
    frame(-1, 0, 0, -1, -10, 1'b0);   // settling frame 2
    frame(-1, 0, 0, -1, -10, 1'b1);   // first capture, 0xAB 0xCD lead pixel
    frame(1, 6, 0, -1, -10, 1'b0);    // short line -> geometry error
    frame(-1, 0, 2, -1, -10, 1'b0);   // good frame, overflow on pixel 2
    frame(-1, 0, 0, -1, -10, 1'b0);   // good frame, errors stay sticky
    frame(-1, 0, 0, 0, 3, 1'b0);      // reset at byte phase 1 of line 0
    frame(-1, 0, 0, -1, -10, 1'b0);   // settling after reset
    frame(-1, 0, 0, -1, -10, 1'b0);   // settling after reset
    frame(0, 7, 0, -1, -10, 1'b0);    // odd byte count on line 0
    vs_pulse();
    repeat (5) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
